// File: rtl/conv_pkg.sv
// Shared types and default sizing for the convolution parameter loader.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } conv_ld_state_t;

    localparam int CONV_DATA_W  = 32;
    localparam int CONV_NUM_KER = 32;
    localparam int CONV_KER_LEN = 27;

endpackage

// File: rtl/conv_param_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// A read and a write to the same address in the same cycle return the old word.
module conv_param_ram
    import conv_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int DEPTH  = CONV_NUM_KER,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage carries no reset so it can map onto a memory macro.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_rdata <= '0;
        end else begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/conv_param_loader.sv
// Loads convolution kernels and biases from two valid/ready streams into RAMs.
// Optional overrun check enabled by defining CONV_LOADER_OVF_CHK_EN.
//
// state | meaning
// IDLE  | no load armed since reset
// LOAD  | accepting kernel and bias beats
// DONE  | all kernels and biases stored
module conv_param_loader
    import conv_pkg::*;
#(
    parameter int DATA_W  = CONV_DATA_W,
    parameter int NUM_KER = CONV_NUM_KER,
    parameter int KER_LEN = CONV_KER_LEN,
    parameter int KI_W    = $clog2(NUM_KER),
    parameter int TAP_W   = $clog2(KER_LEN)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] ker_data,
    input  logic              ker_vld,
    output logic              ker_rdy,
    input  logic [DATA_W-1:0] bias_data,
    input  logic              bias_vld,
    output logic              bias_rdy,
    input  logic [KI_W-1:0]   rd_ker_idx,
    input  logic [TAP_W-1:0]  rd_tap,
    output logic [DATA_W-1:0] rd_ker_data,
    input  logic [KI_W-1:0]   rd_bias_idx,
    output logic [DATA_W-1:0] rd_bias_data,
    output logic              busy,
    output logic              loaded,
    output logic              err
);

    localparam int KER_DEPTH = NUM_KER * KER_LEN;
    localparam int KA_W      = $clog2(KER_DEPTH);

    conv_ld_state_t   r_state, w_state_nxt;
    logic [TAP_W-1:0] r_tap;
    logic [KI_W-1:0]  r_kidx;
    logic [KI_W-1:0]  r_bidx;
    logic             r_ker_done;
    logic             r_bias_done;

    logic             w_ker_fire, w_bias_fire;
    logic             w_tap_last, w_ker_last, w_bias_last;
    logic             w_ker_done_nxt, w_bias_done_nxt;
    logic [KA_W-1:0]  w_ker_waddr, w_ker_raddr;

    assign busy     = (r_state == LOAD);
    assign loaded   = (r_state == DONE);
    assign ker_rdy  = busy && !r_ker_done;
    assign bias_rdy = busy && !r_bias_done;

    // A restart wins over a beat arriving in the same cycle.
    assign w_ker_fire  = ker_vld && ker_rdy && !start;
    assign w_bias_fire = bias_vld && bias_rdy && !start;

    assign w_tap_last  = (r_tap == TAP_W'(KER_LEN - 1));
    assign w_ker_last  = w_tap_last && (r_kidx == KI_W'(NUM_KER - 1));
    assign w_bias_last = (r_bidx == KI_W'(NUM_KER - 1));

    assign w_ker_done_nxt  = r_ker_done || (w_ker_fire && w_ker_last);
    assign w_bias_done_nxt = r_bias_done || (w_bias_fire && w_bias_last);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start) w_state_nxt = LOAD;
            LOAD: if (!start && w_ker_done_nxt && w_bias_done_nxt) w_state_nxt = DONE;
            DONE: if (start) w_state_nxt = LOAD;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_tap       <= '0;
            r_kidx      <= '0;
            r_bidx      <= '0;
            r_ker_done  <= 1'b0;
            r_bias_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (start) begin
                r_tap       <= '0;
                r_kidx      <= '0;
                r_bidx      <= '0;
                r_ker_done  <= 1'b0;
                r_bias_done <= 1'b0;
            end else begin
                if (w_ker_fire) begin
                    if (w_tap_last) begin
                        r_tap  <= '0;
                        r_kidx <= r_kidx + 1'b1;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                    if (w_ker_last) r_ker_done <= 1'b1;
                end
                if (w_bias_fire) begin
                    r_bidx <= r_bidx + 1'b1;
                    if (w_bias_last) r_bias_done <= 1'b1;
                end
            end
        end
    end

`ifdef CONV_LOADER_OVF_CHK_EN
    logic r_err;

    // Outside LOAD both ready outputs are low, so any valid is an overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (start) begin
            r_err <= 1'b0;
        end else if (!busy && ((ker_vld && !ker_rdy) || (bias_vld && !bias_rdy))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign w_ker_waddr = KA_W'(int'(r_kidx) * KER_LEN + int'(r_tap));
    assign w_ker_raddr = KA_W'(int'(rd_ker_idx) * KER_LEN + int'(rd_tap));

    conv_param_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (KER_DEPTH),
        .ADDR_W (KA_W)
    ) u_ker_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_ker_fire),
        .i_waddr (w_ker_waddr),
        .i_wdata (ker_data),
        .i_raddr (w_ker_raddr),
        .o_rdata (rd_ker_data)
    );

    conv_param_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (NUM_KER),
        .ADDR_W (KI_W)
    ) u_bias_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_bias_fire),
        .i_waddr (r_bidx),
        .i_wdata (bias_data),
        .i_raddr (rd_bias_idx),
        .o_rdata (rd_bias_data)
    );

endmodule

// File: tb/tb_conv_param_loader.sv
// Self-checking bench for conv_param_loader: stream loads against a reference
// memory model, read-back through a scoreboard queue, and corner sequences.
module tb_conv_param_loader;

    localparam int NK = 32;
    localparam int KL = 27;
    localparam int KT = NK * KL;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] ker_data = '0;
    logic        ker_vld = 1'b0;
    logic        ker_rdy;
    logic [31:0] bias_data = '0;
    logic        bias_vld = 1'b0;
    logic        bias_rdy;
    logic [4:0]  rd_ker_idx = '0;
    logic [4:0]  rd_tap = '0;
    logic [31:0] rd_ker_data;
    logic [4:0]  rd_bias_idx = '0;
    logic [31:0] rd_bias_data;
    logic        busy;
    logic        loaded;
    logic        err;

    conv_param_loader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .ker_data     (ker_data),
        .ker_vld      (ker_vld),
        .ker_rdy      (ker_rdy),
        .bias_data    (bias_data),
        .bias_vld     (bias_vld),
        .bias_rdy     (bias_rdy),
        .rd_ker_idx   (rd_ker_idx),
        .rd_tap       (rd_tap),
        .rd_ker_data  (rd_ker_data),
        .rd_bias_idx  (rd_bias_idx),
        .rd_bias_data (rd_bias_data),
        .busy         (busy),
        .loaded       (loaded),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] kmem [KT];
    logic [31:0] bmem [NK];

    typedef struct {
        logic [31:0] ek;
        logic [31:0] eb;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int          k;
        int          t;
        int          b;
        logic [31:0] ek;
        logic [31:0] eb;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] kword(input int pat, input int n);
        case (pat)
            0:       return 32'(n + 1);
            1:       return 32'h0000_0007;
            default: return 32'h0000_5000 + 32'(n);
        endcase
    endfunction

    // Read request: address driven now, expectation queued, popped when data appears.
    task automatic rd_issue(input string name, input int k, input int t, input int b,
                            input logic [31:0] ek, input logic [31:0] eb);
        exp_t e;
        rd_ker_idx  = 5'(k);
        rd_tap      = 5'(t);
        rd_bias_idx = 5'(b);
        e.ek = ek;
        e.eb = eb;
        sbq.push_back(e);
        tick;
        e = sbq.pop_front();
        check({name, "_ker"}, rd_ker_data, e.ek);
        check({name, "_bias"}, rd_bias_data, e.eb);
    endtask

    task automatic rd_model(input string name, input int k, input int t, input int b);
        rd_issue(name, k, t, b, kmem[k*KL+t], bmem[b]);
    endtask

    // Pulses start, then streams until both sides complete (or abort_at kernel beats).
    task automatic do_load(input string tag, input int kpat, input int kpct, input int bpct,
                           input int kstall, input int abort_at);
        int kn, bn, stall, cyc_err;
        logic kv, bv, kf, bf, done;
        logic [31:0] kw, bw;
        kn = 0; bn = 0; stall = 0; cyc_err = 0; done = 1'b0;
        ker_vld = 1'b0;
        bias_vld = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        check({tag, "_after_start"}, {28'd0, ker_rdy, bias_rdy, busy, loaded}, 32'b1110);
        for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
            if (abort_at >= 0 && kn == abort_at) break;
            kv = (kn < KT) && ($urandom_range(99) < kpct);
            if (kstall > 0 && bn == NK && stall < kstall && kn < KT) begin
                kv = 1'b0;
                stall++;
            end
            bv = (bn < NK) && ($urandom_range(99) < bpct);
            kw = kword(kpat, kn);
            bw = 32'(100 + bn);
            ker_vld = kv;  ker_data = kw;
            bias_vld = bv; bias_data = bw;
            kf = kv && ker_rdy;
            bf = bv && bias_rdy;
            tick;
            if (kf) begin kmem[kn] = kw; kn++; end
            if (bf) begin bmem[bn] = bw; bn++; end
            done = (kn == KT) && (bn == NK);
            if (ker_rdy !== (kn < KT) || bias_rdy !== (bn < NK) ||
                busy !== !done || loaded !== done) cyc_err++;
        end
        ker_vld = 1'b0;
        bias_vld = 1'b0;
        check({tag, "_cycle_model_errs"}, cyc_err, 0);
        if (abort_at < 0) check({tag, "_completed"}, {31'd0, done}, 1);
        else              check({tag, "_abort_beats"}, kn, abort_at);
        if (kstall > 0)   check({tag, "_stall_cycles"}, stall, kstall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{k: 5,  t: 3,  b: 31, ek: 32'd139, eb: 32'd131};
        vecs[1] = '{k: 0,  t: 0,  b: 0,  ek: 32'd1,   eb: 32'd100};
        vecs[2] = '{k: 31, t: 26, b: 1,  ek: 32'd864, eb: 32'd101};
        vecs[3] = '{k: 1,  t: 0,  b: 16, ek: 32'd28,  eb: 32'd116};
        vecs[4] = '{k: 26, t: 13, b: 30, ek: 32'd716, eb: 32'd130};

        // Reset state
        #2 reset_n = 1'b0;
        repeat (3) tick;
        check("rst_flags", {27'd0, ker_rdy, bias_rdy, busy, loaded, err}, 32'd0);
        check("rst_rd_ker", rd_ker_data, 32'd0);
        check("rst_rd_bias", rd_bias_data, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) tick;
        check("idle_no_rdy", {29'd0, ker_rdy, bias_rdy, busy}, 32'd0);

        // Sequential words with vld held high, then table-driven reads
        do_load("seq", 0, 100, 100, 0, -1);
        for (int i = 0; i < 5; i++) begin
            rd_issue($sformatf("seq_vec%0d", i), vecs[i].k, vecs[i].t, vecs[i].b,
                     vecs[i].ek, vecs[i].eb);
        end

        // Equal words with random vld gaps; every tap reads back 7
        do_load("rand7", 1, 50, 40, 0, -1);
        for (int a = 0; a < KT; a++) begin
            rd_issue($sformatf("rand7_a%0d", a), a / KL, a % KL, a % NK,
                     32'h0000_0007, 32'(100 + a % NK));
        end

        // Biases finish first, kernels stall 50 cycles afterwards
        do_load("stall", 0, 100, 100, 50, -1);
        rd_model("stall_rd", 5, 3, 31);

        // Restart after 100 kernel beats; first new word lands at kernel 0 tap 0
        do_load("abort", 0, 100, 100, 0, 100);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("restart_rdy", {30'd0, ker_rdy, bias_rdy}, 32'b11);
        ker_vld = 1'b1;
        ker_data = 32'h0000_5000;
        rd_issue("restart_rbw", 0, 0, 0, 32'd1, 32'd100);
        ker_vld = 1'b0;
        kmem[0] = 32'h0000_5000;
        rd_issue("restart_tap0", 0, 0, 0, 32'h0000_5000, 32'd100);
        do_load("reload", 2, 100, 100, 0, -1);
        rd_issue("reload_tap0", 0, 0, 0, 32'h0000_5000, 32'd100);
        rd_model("reload_tap1", 0, 1, 2);
        rd_model("reload_last", 31, 26, 31);

        // Overrun in DONE
        ker_vld = 1'b1;
        tick;
        ker_vld = 1'b0;
`ifdef CONV_LOADER_OVF_CHK_EN
        check("err_set", {31'd0, err}, 32'd1);
        tick;
        check("err_sticky", {31'd0, err}, 32'd1);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("err_clear", {31'd0, err}, 32'd0);
`else
        check("err_tied", {31'd0, err}, 32'd0);
        tick;
        check("err_tied2", {31'd0, err}, 32'd0);
`endif

        // Asynchronous reset in the middle of a load
        do_load("prerst", 0, 100, 100, 0, 200);
        rd_model("prerst_rd", 0, 1, 3);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_flags", {27'd0, ker_rdy, bias_rdy, busy, loaded, err}, 32'd0);
        check("async_rst_rd_ker", rd_ker_data, 32'd0);
        check("async_rst_rd_bias", rd_bias_data, 32'd0);
        tick;
        @(negedge clk) reset_n = 1'b1;
        repeat (3) tick;
        check("post_rst_idle", {29'd0, ker_rdy, busy, loaded}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_param_loader.md
# conv_param_loader

Parametrised parameter loader for a convolution layer. It accepts kernel weights and biases over two independent valid/ready streams and writes them into on-chip buffers. It flags completion and serves the stored values to the convolution datapath through registered random-access read ports. Every beat is counted on a true `vld && rdy` handshake; word values are never inspected. Kernel count, kernel length and data width are parameters.

## Interface
- `DATA_W`, 32, width of kernel and bias words
- `NUM_KER`, 32, number of kernels (output channels); also the number of biases
- `KER_LEN`, 27, words per kernel (kh*kw*cin)
- `KI_W`, `$clog2(NUM_KER)`, kernel/bias index width (derived)
- `TAP_W`, `$clog2(KER_LEN)`, tap index width (derived)

- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; arms or restarts a load
- `ker_data`  in  DATA_W  kernel word, kernel-major order (all taps of kernel 0 first)
- `ker_vld`  in  1  kernel word valid
- `ker_rdy`  out  1  loader can accept a kernel word
- `bias_data`  in  DATA_W  bias word, bias 0 first
- `bias_vld`  in  1  bias valid
- `bias_rdy`  out  1  loader can accept a bias
- `rd_ker_idx`  in  KI_W  kernel read select
- `rd_tap`  in  TAP_W  tap read select
- `rd_ker_data`  out  DATA_W  registered kernel read data
- `rd_bias_idx`  in  KI_W  bias read select
- `rd_bias_data`  out  DATA_W  registered bias read data
- `busy`  out  1  load in progress
- `loaded`  out  1  all kernels and biases stored
- `err`  out  1  sticky protocol error; constant 0 unless `CONV_LOADER_OVF_CHK_EN` is defined

## Operation
- Three-state FSM:
  - IDLE to LOAD on `start`.
  - LOAD to DONE when both the kernel and bias streams are complete.
  - DONE to LOAD on `start`.
  - `start` in LOAD restarts the load: counters clear and stored data is overwritten by the new load.
- Kernel write address:
  - `tap` counts 0..KER_LEN-1 and wraps to 0 after the last tap.
  - On each wrap, `kidx` increments.
  - The kernel stream completes after the accepted beat with `kidx==NUM_KER-1` and `tap==KER_LEN-1`.
- Bias counter counts 0..NUM_KER-1. The bias stream completes after the accepted beat at index NUM_KER-1.
- `ker_rdy` = (state==LOAD) && kernel stream not complete. `bias_rdy` follows the same rule for biases.
  - Both are decoded from registers only and never depend on `*_vld`.
- The two streams are independent; either may finish first and may stall arbitrarily.
- `busy` = (state==LOAD). `loaded` = (state==DONE).
- Reads are always allowed.
  - During LOAD, a read returns the old or partially loaded contents.
  - A read and write to the same address in the same cycle returns the old value.
- Equal consecutive words are legal and each one counts as a beat.
- Reset values: `ker_rdy`, `bias_rdy`, `busy`, `loaded`, `err` = 0; `rd_ker_data`, `rd_bias_data` = 0. Buffer contents are undefined after reset.
- Reset mid-load: all outputs drop to their reset values immediately (asynchronously). A new `start` is needed to reload.

## Timing
- `start` sampled at cycle t: `busy`, `ker_rdy` and `bias_rdy` are high from t+1.
- A beat is accepted in any cycle where `vld && rdy` holds at the clock edge. There is no bubble between beats.
- Final kernel beat at t: `ker_rdy` is low from t+1. The same applies to biases.
- The later of the two final beats at t: `loaded`=1 and `busy`=0 at t+1.
- Minimum load time is max(NUM_KER*KER_LEN, NUM_KER) + 1 cycles after `start`.
- Read latency is 1 cycle: the address at t gives data at t+1.

## Configuration
- `CONV_LOADER_OVF_CHK_EN` defined:
  - `err` sets in the cycle after `ker_vld` or `bias_vld` is high while that stream's `rdy` is low outside LOAD (an overrun in IDLE or DONE).
  - `err` is sticky and clears on `start` or reset.
- Not defined: `err` is tied to 0 and no check logic is built.

## Structure
- Package `conv_pkg` holds:
  - the `conv_ld_state_t` enum (IDLE, LOAD, DONE);
  - default constants `CONV_DATA_W`=32, `CONV_NUM_KER`=32, `CONV_KER_LEN`=27.
- Sub-module `conv_param_ram`:
  - parametrised simple dual-port synchronous RAM: 1 write port, 1 registered read port, read-before-write;
  - instantiated twice: kernels (depth NUM_KER*KER_LEN, address `kidx*KER_LEN+tap`) and biases (depth NUM_KER).

## Test plan
- Reset asserted mid-simulation: every output is 0 immediately; after release, `ker_rdy`=0 until `start`.
- `start`, then 864 kernel words w+1 (w=0..863) and 32 biases 100+i, with `vld` held high:
  - `loaded` rises the cycle after the 864th kernel beat;
  - read kernel 5, tap 3 gives 139 one cycle later;
  - read bias 31 gives 131.
- All 864 kernel words = 0x0000_0007, with `vld` toggled randomly: `loaded` rises only after exactly 864 handshakes, and every tap reads back 7.
- Biases finish first and kernels stall 50 cycles: `bias_rdy`=0 after bias 31, `busy` stays 1, and `loaded` follows the last kernel beat.
- `start` pulsed after 100 kernel beats: the counters restart, and kernel 0, tap 0 holds the first word sent after the restart.
- With `CONV_LOADER_OVF_CHK_EN` defined, `ker_vld`=1 in DONE: `err`=1 next cycle, stays set, and clears on the next `start`.
